// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - data-memory bus between the arbiter and the memory
// Purpose: groups the single data-memory port that the arbiter owns.
// Signals:
//   mem_rd, mem_wr  read / write strobes towards memory
//   mem_addr        byte address (DM_ADDRESS bits)
//   mem_wdata       write data (DATA_W bits)
//   mem_func3       access size/sign code passed through from the winner
//   mem_rdata       read data, valid combinationally in the request cycle
// Modports: master = arbiter side, slave = memory side.
interface dmem_arbiter_if #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9
);
    logic                  mem_rd;
    logic                  mem_wr;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [2:0]            mem_func3;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output mem_rd, mem_wr, mem_addr, mem_wdata, mem_func3,
        input  mem_rdata
    );

    modport slave (
        input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_func3,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core / debug arbiter for a single data-memory port
// Purpose: shares one data-memory port between the MEM stage and a debug/loader
//   port. The core has priority; with DMEM_ARB_STARVE_EN defined, a debug request
//   refused STARVE_LIM consecutive cycles is forced through (core stalls one cycle).
//   Without DMEM_ARB_STARVE_EN the core has strict priority and STARVE_LIM is unused.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   core_rd/wr/addr/wdata/func3, core_stall, core_rdata   MEM-stage access
//   dbg_valid/we/addr/wdata/func3, dbg_ready              debug request handshake
//   dbg_rvalid, dbg_rdata      debug read response, one cycle after acceptance
//   owner                      last cycle's winner (0 idle, 1 core, 2 debug), debug view
//   mem                        data-memory bus (dmem_arbiter_if.master)
module dmem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int STARVE_LIM = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_rd,
    input  logic                  core_wr,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wdata,
    input  logic [2:0]            core_func3,
    output logic                  core_stall,
    output logic [DATA_W-1:0]     core_rdata,
    input  logic                  dbg_valid,
    input  logic                  dbg_we,
    input  logic [DM_ADDRESS-1:0] dbg_addr,
    input  logic [DATA_W-1:0]     dbg_wdata,
    input  logic [2:0]            dbg_func3,
    output logic                  dbg_ready,
    output logic                  dbg_rvalid,
    output logic [DATA_W-1:0]     dbg_rdata,
    output logic [1:0]            owner,
    dmem_arbiter_if.master        mem
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    owner_e              winner;
    owner_e              owner_q, owner_d;
    logic                dbg_rvalid_q, dbg_rvalid_d;
    logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
    logic                core_req;
    logic                force_dbg;

    assign core_req = core_rd | core_wr;

`ifdef DMEM_ARB_STARVE_EN
    localparam logic [3:0] STARVE_LIM_C = 4'(STARVE_LIM);

    logic [3:0] starve_q, starve_d;

    assign force_dbg = dbg_valid && (starve_q == STARVE_LIM_C);

    // Counts consecutive refused debug cycles; any gap in dbg_valid restarts it.
    always_comb begin
        starve_d = starve_q;
        if (!dbg_valid || winner == OWN_DBG) begin
            starve_d = 4'd0;
        end else if (starve_q < STARVE_LIM_C) begin
            starve_d = starve_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_q <= 4'd0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_dbg = 1'b0;
`endif

    // Winner selection and the owner FSM next state: owner simply records
    // this cycle's winner and never feeds back into arbitration.
    always_comb begin
        winner = OWN_IDLE;
        if (force_dbg) begin
            winner = OWN_DBG;
        end else if (core_req) begin
            winner = OWN_CORE;
        end else if (dbg_valid) begin
            winner = OWN_DBG;
        end
        owner_d = winner;
    end

    always_comb begin
        mem.mem_rd    = 1'b0;
        mem.mem_wr    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        mem.mem_func3 = 3'd0;
        case (winner)
            OWN_CORE: begin
                mem.mem_rd    = core_rd;
                mem.mem_wr    = core_wr;
                mem.mem_addr  = core_addr;
                mem.mem_wdata = core_wdata;
                mem.mem_func3 = core_func3;
            end
            OWN_DBG: begin
                mem.mem_rd    = ~dbg_we;
                mem.mem_wr    = dbg_we;
                mem.mem_addr  = dbg_addr;
                mem.mem_wdata = dbg_wdata;
                mem.mem_func3 = dbg_func3;
            end
            default: ;
        endcase
    end

    assign core_stall = core_req && (winner != OWN_CORE);
    assign core_rdata = mem.mem_rdata;
    assign dbg_ready  = (winner == OWN_DBG);

    // Read response: winner == OWN_DBG implies dbg_valid, so this is the accept.
    always_comb begin
        dbg_rvalid_d = (winner == OWN_DBG) && !dbg_we;
        dbg_rdata_d  = dbg_rdata_q;
        if (dbg_rvalid_d) begin
            dbg_rdata_d = mem.mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q      <= OWN_IDLE;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            owner_q      <= owner_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    assign dbg_rvalid = dbg_rvalid_q;
    assign dbg_rdata  = dbg_rdata_q;
    assign owner      = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    localparam int DW  = 32;
    localparam int AW  = 9;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_rd, core_wr;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata;
    logic [2:0]    core_func3;
    logic          core_stall;
    logic [DW-1:0] core_rdata;
    logic          dbg_valid, dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [2:0]    dbg_func3;
    logic          dbg_ready, dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic [1:0]    owner;
    logic [DW-1:0] tb_mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    dmem_arbiter_if #(.DATA_W(DW), .DM_ADDRESS(AW)) mem_bus ();
    assign mem_bus.mem_rdata = tb_mem_rdata;

    dmem_arbiter #(.DATA_W(DW), .DM_ADDRESS(AW), .STARVE_LIM(LIM)) dut (
        .clk        (clk),
        .reset      (reset),
        .core_rd    (core_rd),
        .core_wr    (core_wr),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_func3 (core_func3),
        .core_stall (core_stall),
        .core_rdata (core_rdata),
        .dbg_valid  (dbg_valid),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_func3  (dbg_func3),
        .dbg_ready  (dbg_ready),
        .dbg_rvalid (dbg_rvalid),
        .dbg_rdata  (dbg_rdata),
        .owner      (owner),
        .mem        (mem_bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // who: 0 nobody, 1 core, 2 debug
    int            m_starve = 0;
    int            m_owner  = 0;
    bit            m_rvalid = 0;
    logic [DW-1:0] m_rdata  = '0;

    function automatic int who_wins();
        bit creq = core_rd | core_wr;
`ifdef DMEM_ARB_STARVE_EN
        if (dbg_valid && m_starve == LIM) return 2;
`endif
        if (creq) return 1;
        if (dbg_valid) return 2;
        return 0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_starve = 0;
            m_owner  = 0;
            m_rvalid = 0;
            m_rdata  = '0;
        end else begin
            int w;
            w = who_wins();
            m_owner  = w;
            m_rvalid = (w == 2) && !dbg_we;
            if (m_rvalid) m_rdata = tb_mem_rdata;
            if (!dbg_valid || w == 2) m_starve = 0;
            else if (m_starve < LIM) m_starve = m_starve + 1;
        end
    end

    always @(negedge clk) begin
        int            w;
        bit            e_rd, e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic [2:0]    e_f3;
        w = who_wins();
        e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0; e_f3 = '0;
        if (w == 1) begin
            e_rd = core_rd; e_wr = core_wr; e_addr = core_addr;
            e_wdata = core_wdata; e_f3 = core_func3;
        end else if (w == 2) begin
            e_rd = !dbg_we; e_wr = dbg_we; e_addr = dbg_addr;
            e_wdata = dbg_wdata; e_f3 = dbg_func3;
        end
        chk("mem_rd",     64'(mem_bus.mem_rd),    64'(e_rd));
        chk("mem_wr",     64'(mem_bus.mem_wr),    64'(e_wr));
        chk("mem_addr",   64'(mem_bus.mem_addr),  64'(e_addr));
        chk("mem_wdata",  64'(mem_bus.mem_wdata), 64'(e_wdata));
        chk("mem_func3",  64'(mem_bus.mem_func3), 64'(e_f3));
        chk("core_stall", 64'(core_stall), 64'((core_rd | core_wr) && w != 1));
        chk("core_rdata", 64'(core_rdata), 64'(tb_mem_rdata));
        chk("dbg_ready",  64'(dbg_ready),  64'(w == 2));
        chk("dbg_rvalid", 64'(dbg_rvalid), 64'(m_rvalid));
        chk("dbg_rdata",  64'(dbg_rdata),  64'(m_rdata));
        chk("owner",      64'(owner),      64'(m_owner));
    end

    // ---------------- stimulus ----------------
    task automatic idle_inputs();
        core_rd = 0; core_wr = 0; core_addr = '0; core_wdata = '0; core_func3 = '0;
        dbg_valid = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0; dbg_func3 = '0;
        tb_mem_rdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  first;
        bit  last_ready;
        idle_inputs();
        reset = 0;
        step();
        step();
        // reset state
        chk("rst_rvalid", 64'(dbg_rvalid), 64'd0);
        chk("rst_rdata",  64'(dbg_rdata),  64'd0);
        chk("rst_owner",  64'(owner),      64'd0);
        reset = 1;
        step();

        // core read, no debug
        core_rd = 1; core_addr = 9'h010; core_func3 = 3'd2; tb_mem_rdata = 32'hA5A5_0001;
        @(negedge clk);
        chk("t1_mem_rd",   64'(mem_bus.mem_rd),   64'd1);
        chk("t1_mem_addr", 64'(mem_bus.mem_addr), 64'h010);
        chk("t1_stall",    64'(core_stall),       64'd0);
        chk("t1_rdata",    64'(core_rdata),       64'hA5A5_0001);
        step();

        // debug write, no core
        idle_inputs();
        dbg_valid = 1; dbg_we = 1; dbg_addr = 9'h020; dbg_wdata = 32'hDEAD_BEEF; dbg_func3 = 3'd2;
        @(negedge clk);
        chk("t2_ready",  64'(dbg_ready),         64'd1);
        chk("t2_mem_wr", 64'(mem_bus.mem_wr),    64'd1);
        chk("t2_wdata",  64'(mem_bus.mem_wdata), 64'hDEAD_BEEF);
        step();
        idle_inputs();
        @(negedge clk);
        chk("t2_no_rvalid", 64'(dbg_rvalid), 64'd0);
        chk("t2_owner",     64'(owner),      64'd2);
        step();

        // debug read
        dbg_valid = 1; dbg_we = 0; dbg_addr = 9'h040; tb_mem_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("t3_ready", 64'(dbg_ready), 64'd1);
        step();
        idle_inputs();
        @(negedge clk);
        chk("t3_rvalid", 64'(dbg_rvalid), 64'd1);
        chk("t3_rdata",  64'(dbg_rdata),  64'h1234_5678);
        step();
        @(negedge clk);
        chk("t3_rvalid_drop", 64'(dbg_rvalid), 64'd0);
        chk("t3_rdata_hold",  64'(dbg_rdata),  64'h1234_5678);
        step();

        // simultaneous core write and debug read: core first, debug next
        core_wr = 1; core_addr = 9'h0F0; core_wdata = 32'h0000_00FF;
        dbg_valid = 1; dbg_we = 0; dbg_addr = 9'h044; tb_mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        chk("t4_ready", 64'(dbg_ready),      64'd0);
        chk("t4_wr",    64'(mem_bus.mem_wr), 64'd1);
        chk("t4_stall", 64'(core_stall),     64'd0);
        step();
        core_wr = 0;
        @(negedge clk);
        chk("t4_ready2", 64'(dbg_ready), 64'd1);
        step();

        // back-to-back debug reads
        for (int i = 0; i < 3; i++) begin
            dbg_addr = 9'(9'h080 + 4 * i);
            tb_mem_rdata = 32'hB000_0000 + 32'(i);
            step();
        end
        idle_inputs();
        @(negedge clk);
        chk("t5_rvalid", 64'(dbg_rvalid), 64'd1);
        chk("t5_rdata",  64'(dbg_rdata),  64'hB000_0002);
        step();

        // continuous core requests with a pending debug read
        first = 0;
        core_rd = 1; dbg_valid = 1; dbg_we = 0; dbg_addr = 9'h100; tb_mem_rdata = 32'h7777_0000;
        for (int i = 1; i <= 10; i++) begin
            core_addr = 9'(i * 4);
            @(negedge clk);
            if (dbg_ready && first == 0) first = i;
            step();
            if (first != 0) dbg_valid = 0;
        end
`ifdef DMEM_ARB_STARVE_EN
        chk("starve_grant_cycle", 64'(first), 64'd5);
`else
        chk("starve_grant_cycle", 64'(first), 64'd0);
`endif
        idle_inputs();
        step();

        // reset one cycle after a debug read accept
        dbg_valid = 1; dbg_we = 0; dbg_addr = 9'h0AA; tb_mem_rdata = 32'hCAFE_F00D;
        step();
        idle_inputs();
        chk("t7_rvalid_pre", 64'(dbg_rvalid), 64'd1);
        reset = 0;
        #1;
        chk("t7_rvalid_rst", 64'(dbg_rvalid), 64'd0);
        chk("t7_rdata_rst",  64'(dbg_rdata),  64'd0);
        chk("t7_owner_rst",  64'(owner),      64'd0);
        step();
        reset = 1;
        @(negedge clk);
        chk("t7_rvalid_post", 64'(dbg_rvalid), 64'd0);
        step();

        // mixed traffic, debug inputs held while waiting
        last_ready = 1;
        for (int i = 0; i < 60; i++) begin
            core_rd    = ($urandom_range(0, 9) < 4);
            core_wr    = !core_rd && ($urandom_range(0, 9) < 3);
            core_addr  = 9'($urandom);
            core_wdata = $urandom;
            core_func3 = 3'($urandom);
            if (!(dbg_valid && !last_ready)) begin
                dbg_valid = ($urandom_range(0, 1) == 1);
                dbg_we    = ($urandom_range(0, 1) == 1);
                dbg_addr  = 9'($urandom);
                dbg_wdata = $urandom;
                dbg_func3 = 3'($urandom);
            end
            tb_mem_rdata = $urandom;
            @(negedge clk);
            last_ready = dbg_ready;
            step();
        end
        idle_inputs();
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
